cache_ctrl_wb: RTL and testbench

Parametrised successor to the current cache controller. It is a direct-mapped, write-back, write-allocate cache with one data word per line. It sits between the CPU-side request port and the main-memory model, on a single clock. Compared with the current controller it adds parametrised geometry, dirty-line write-back, a full-cache flush command and saturating hit/miss counters.

---
 rtl/cache_ctrl_wb_if.sv | 36 +++
 rtl/cache_ctrl_wb.sv | 202 ++++++++++++++++++++
 tb/tb_cache_ctrl_wb.sv | 391 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_ctrl_wb_if.sv
// rtl/cache_ctrl_wb_if.sv - CPU request, flush, memory and counter signals of cache_ctrl_wb
interface cache_ctrl_wb_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
);
    logic              req_valid;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              req_ready;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_rdata;
    logic              flush_req;
    logic              flush_done;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;
    logic [CNT_W-1:0]  hit_cnt;
    logic [CNT_W-1:0]  miss_cnt;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, flush_req, mem_ack, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, flush_done,
               mem_req, mem_we, mem_addr, mem_wdata, hit_cnt, miss_cnt
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, flush_req, mem_ack, mem_rdata,
        output req_ready, resp_valid, resp_rdata, flush_done,
               mem_req, mem_we, mem_addr, mem_wdata, hit_cnt, miss_cnt
    );
endinterface

// File: rtl/cache_ctrl_wb.sv
// rtl/cache_ctrl_wb.sv - direct-mapped write-back write-allocate cache controller, one word per line
module cache_ctrl_wb #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int LINES  = 4,
    parameter int CNT_W  = 16
) (
    input  logic           clk,
    input  logic           rst,
    cache_ctrl_wb_if.slave bus
);
    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = ADDR_W - IDX_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LINES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOOKUP, S_WRITEBACK, S_REFILL, S_RESPOND, S_FLUSH_SCAN, S_FLUSH_WB
    } state_t;

    state_t            r_state;
    logic [TAG_W-1:0]  r_tag  [LINES];
    logic [DATA_W-1:0] r_data [LINES];
    logic [LINES-1:0]  r_valid;
    logic [LINES-1:0]  r_dirty;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [IDX_W-1:0]  r_scan;
    logic              r_req_ready;
    logic              r_resp_valid;
    logic [DATA_W-1:0] r_resp_rdata;
    logic              r_flush_done;
    logic              r_mem_req;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [CNT_W-1:0]  r_hit_cnt;
    logic [CNT_W-1:0]  r_miss_cnt;

    logic [IDX_W-1:0]  w_idx;
    logic [TAG_W-1:0]  w_tag;
    logic              w_hit;
    logic              w_victim_dirty;
    logic              w_scan_dirty;

    assign w_idx          = r_addr[IDX_W-1:0];
    assign w_tag          = r_addr[ADDR_W-1:IDX_W];
    assign w_hit          = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_victim_dirty = r_valid[w_idx] && r_dirty[w_idx];
    assign w_scan_dirty   = r_valid[r_scan] && r_dirty[r_scan];

    // Tag and data arrays are deliberately left out of the reset branch.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_valid      <= '0;
            r_dirty      <= '0;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_scan       <= '0;
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= '0;
            r_flush_done <= 1'b0;
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_hit_cnt    <= '0;
            r_miss_cnt   <= '0;
        end else begin
            r_resp_valid <= 1'b0;
            r_flush_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.flush_req) begin
                        r_scan      <= '0;
                        r_req_ready <= 1'b0;
                        r_state     <= S_FLUSH_SCAN;
                    end else if (bus.req_valid) begin
                        r_we        <= bus.req_we;
                        r_addr      <= bus.req_addr;
                        r_wdata     <= bus.req_wdata;
                        r_req_ready <= 1'b0;
                        r_state     <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    if (w_hit) begin
                        if (r_hit_cnt != '1) r_hit_cnt <= r_hit_cnt + CNT_W'(1);
                        if (r_we) begin
                            r_data[w_idx]  <= r_wdata;
                            r_dirty[w_idx] <= 1'b1;
                        end else begin
                            r_resp_rdata <= r_data[w_idx];
                        end
                        r_state <= S_RESPOND;
                    end else begin
                        if (r_miss_cnt != '1) r_miss_cnt <= r_miss_cnt + CNT_W'(1);
                        if (w_victim_dirty) begin
                            r_mem_req   <= 1'b1;
                            r_mem_we    <= 1'b1;
                            r_mem_addr  <= {r_tag[w_idx], w_idx};
                            r_mem_wdata <= r_data[w_idx];
                            r_state     <= S_WRITEBACK;
                        end else if (!r_we) begin
                            r_state <= S_REFILL;
                        end else begin
                            r_data[w_idx]  <= r_wdata;
                            r_tag[w_idx]   <= w_tag;
                            r_valid[w_idx] <= 1'b1;
                            r_dirty[w_idx] <= 1'b1;
                            r_state        <= S_RESPOND;
                        end
                    end
                end
                S_WRITEBACK: begin
                    if (bus.mem_ack) begin
                        r_mem_req <= 1'b0;
                        r_mem_we  <= 1'b0;
                        if (r_we) begin
                            r_data[w_idx]  <= r_wdata;
                            r_tag[w_idx]   <= w_tag;
                            r_valid[w_idx] <= 1'b1;
                            r_dirty[w_idx] <= 1'b1;
                            r_state        <= S_RESPOND;
                        end else begin
                            r_state <= S_REFILL;
                        end
                    end
                end
                // First REFILL cycle raises the read, so mem_req is always low for a cycle after an ack.
                S_REFILL: begin
                    if (!r_mem_req) begin
                        r_mem_req  <= 1'b1;
                        r_mem_we   <= 1'b0;
                        r_mem_addr <= r_addr;
                    end else if (bus.mem_ack) begin
                        r_mem_req      <= 1'b0;
                        r_data[w_idx]  <= bus.mem_rdata;
                        r_tag[w_idx]   <= w_tag;
                        r_valid[w_idx] <= 1'b1;
                        r_dirty[w_idx] <= 1'b0;
                        r_resp_rdata   <= bus.mem_rdata;
                        r_state        <= S_RESPOND;
                    end
                end
                S_RESPOND: begin
                    r_resp_valid <= 1'b1;
                    r_req_ready  <= 1'b1;
                    r_state      <= S_IDLE;
                end
                S_FLUSH_SCAN: begin
                    if (w_scan_dirty) begin
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= 1'b1;
                        r_mem_addr  <= {r_tag[r_scan], r_scan};
                        r_mem_wdata <= r_data[r_scan];
                        r_state     <= S_FLUSH_WB;
                    end else if (r_scan == LAST_IDX) begin
                        r_flush_done <= 1'b1;
                        r_req_ready  <= 1'b1;
                        r_state      <= S_IDLE;
                    end else begin
                        r_scan <= r_scan + IDX_W'(1);
                    end
                end
                S_FLUSH_WB: begin
                    if (bus.mem_ack) begin
                        r_mem_req       <= 1'b0;
                        r_mem_we        <= 1'b0;
                        r_dirty[r_scan] <= 1'b0;
                        if (r_scan == LAST_IDX) begin
                            r_flush_done <= 1'b1;
                            r_req_ready  <= 1'b1;
                            r_state      <= S_IDLE;
                        end else begin
                            r_scan  <= r_scan + IDX_W'(1);
                            r_state <= S_FLUSH_SCAN;
                        end
                    end
                end
                default: begin
                    r_req_ready <= 1'b1;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready  = r_req_ready;
    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_rdata = r_resp_rdata;
    assign bus.flush_done = r_flush_done;
    assign bus.mem_req    = r_mem_req;
    assign bus.mem_we     = r_mem_we;
    assign bus.mem_addr   = r_mem_addr;
    assign bus.mem_wdata  = r_mem_wdata;
    assign bus.hit_cnt    = r_hit_cnt;
    assign bus.miss_cnt   = r_miss_cnt;
endmodule

// File: tb/tb_cache_ctrl_wb.sv
// tb/tb_cache_ctrl_wb.sv - scoreboard bench for cache_ctrl_wb with a reference cache and memory model
`timescale 1ns/1ps
module tb_cache_ctrl_wb;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    typedef struct { bit is_read; logic [7:0] data; int hit; int miss; } resp_t;
    typedef struct { bit we; logic [7:0] addr; logic [7:0] data; } memop_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cache_ctrl_wb_if #(.ADDR_W(8), .DATA_W(8), .CNT_W(CNT_W)) bus ();
    cache_ctrl_wb #(.ADDR_W(8), .DATA_W(8), .LINES(4), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    int n_vec = 0;
    int n_err = 0;
    int mem_delay = 1;
    bit spurious = 0;
    logic [7:0] mem   [256];
    logic [7:0] m_mem [256];
    bit         m_valid [4];
    bit         m_dirty [4];
    logic [5:0] m_tag   [4];
    logic [7:0] m_data  [4];
    int m_hit, m_miss;
    resp_t  exp_resp [$];
    memop_t exp_mem  [$];

    function automatic void model_reset();
        for (int i = 0; i < 4; i++) begin m_valid[i] = 0; m_dirty[i] = 0; end
        m_hit = 0; m_miss = 0;
    endfunction

    function automatic void model_access(input bit we, input logic [7:0] a, input logic [7:0] wd);
        int i; logic [5:0] t; memop_t mo; resp_t r;
        i = int'(a[1:0]); t = a[7:2];
        if (m_valid[i] && m_tag[i] == t) begin
            if (m_hit < CNT_MAX) m_hit++;
            if (we) begin m_data[i] = wd; m_dirty[i] = 1; end
        end else begin
            if (m_miss < CNT_MAX) m_miss++;
            if (m_valid[i] && m_dirty[i]) begin
                mo.we = 1; mo.addr = {m_tag[i], a[1:0]}; mo.data = m_data[i];
                exp_mem.push_back(mo);
                m_mem[mo.addr] = m_data[i];
            end
            if (we) begin
                m_data[i] = wd; m_dirty[i] = 1;
            end else begin
                mo.we = 0; mo.addr = a; mo.data = 8'h00;
                exp_mem.push_back(mo);
                m_data[i] = m_mem[a]; m_dirty[i] = 0;
            end
            m_valid[i] = 1; m_tag[i] = t;
        end
        r.is_read = !we; r.data = m_data[i]; r.hit = m_hit; r.miss = m_miss;
        exp_resp.push_back(r);
    endfunction

    function automatic void model_flush();
        memop_t mo;
        for (int i = 0; i < 4; i++) begin
            if (m_valid[i] && m_dirty[i]) begin
                mo.we = 1; mo.addr = {m_tag[i], 2'(i)}; mo.data = m_data[i];
                exp_mem.push_back(mo);
                m_mem[mo.addr] = m_data[i];
                m_dirty[i] = 0;
            end
        end
    endfunction

    // Memory model: acks after mem_delay sampled request cycles, checks each access against the scoreboard.
    initial begin
        int wait_cnt;
        memop_t e;
        wait_cnt = 0;
        bus.mem_ack = 1'b0; bus.mem_rdata = 8'h00;
        forever begin
            @(negedge clk);
            bus.mem_ack = 1'b0;
            if (bus.mem_req === 1'b1) begin
                wait_cnt++;
                if (wait_cnt >= mem_delay) begin
                    wait_cnt = 0;
                    n_vec++;
                    if (exp_mem.size() == 0) begin
                        n_err++;
                        $display("FAIL mem_unexpected: got we=%0b addr=%h wdata=%h, required no access",
                                 bus.mem_we, bus.mem_addr, bus.mem_wdata);
                    end else begin
                        e = exp_mem.pop_front();
                        if (bus.mem_we !== e.we || bus.mem_addr !== e.addr || (e.we && bus.mem_wdata !== e.data)) begin
                            n_err++;
                            $display("FAIL mem_op: got we=%0b addr=%h wdata=%h, required we=%0b addr=%h wdata=%h",
                                     bus.mem_we, bus.mem_addr, bus.mem_wdata, e.we, e.addr, e.data);
                        end
                    end
                    if (bus.mem_we === 1'b1) mem[bus.mem_addr] = bus.mem_wdata;
                    else bus.mem_rdata = mem[bus.mem_addr];
                    bus.mem_ack = 1'b1;
                end
            end else begin
                wait_cnt = 0;
                if (spurious) begin bus.mem_ack = 1'b1; bus.mem_rdata = 8'hEE; end
            end
        end
    end

    // Response scoreboard.
    initial forever begin
        resp_t e;
        @(negedge clk);
        if (bus.resp_valid === 1'b1) begin
            n_vec++;
            if (exp_resp.size() == 0) begin
                n_err++;
                $display("FAIL resp_unexpected: got resp_valid=1 rdata=%h, required no response", bus.resp_rdata);
            end else begin
                e = exp_resp.pop_front();
                if ((e.is_read && bus.resp_rdata !== e.data) || bus.hit_cnt !== CNT_W'(e.hit) || bus.miss_cnt !== CNT_W'(e.miss)) begin
                    n_err++;
                    $display("FAIL resp: got rdata=%h hit=%0d miss=%0d, required rdata=%h(read=%0b) hit=%0d miss=%0d",
                             bus.resp_rdata, bus.hit_cnt, bus.miss_cnt, e.data, e.is_read, e.hit, e.miss);
                end
            end
        end
    end

    task automatic issue(input bit we, input logic [7:0] a, input logic [7:0] wd);
        int b;
        b = 0;
        while (bus.req_ready !== 1'b1 && b < 300) begin @(negedge clk); b++; end
        if (b >= 300) begin
            n_vec++; n_err++;
            $display("FAIL issue_timeout: req_ready got %b, required 1", bus.req_ready);
        end
        model_access(we, a, wd);
        bus.req_valid = 1'b1; bus.req_we = we; bus.req_addr = a; bus.req_wdata = wd;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_resp(output int lat);
        lat = 0;
        do begin @(negedge clk); lat++; end while (bus.resp_valid !== 1'b1 && lat < 300);
        if (lat >= 300) begin
            n_vec++; n_err++;
            $display("FAIL resp_timeout: resp_valid got %b, required 1", bus.resp_valid);
        end
    endtask

    task automatic pulse_flush();
        @(negedge clk);
        bus.flush_req = 1'b1;
        @(posedge clk); #1;
        bus.flush_req = 1'b0;
    endtask

    task automatic wait_flush();
        int b;
        b = 0;
        do begin @(negedge clk); b++; end while (bus.flush_done !== 1'b1 && b < 300);
        n_vec++;
        if (b >= 300) begin n_err++; $display("FAIL flush_timeout: flush_done got %b, required 1", bus.flush_done); end
        n_vec++;
        if (exp_mem.size() != 0) begin
            n_err++; $display("FAIL flush_pending: got %0d outstanding mem ops, required 0", exp_mem.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.req_valid = 0; bus.req_we = 0; bus.req_addr = 0; bus.req_wdata = 0; bus.flush_req = 0;
        model_reset();
        repeat (3) @(negedge clk);
        n_vec++;
        if (bus.req_ready !== 1'b1) begin n_err++; $display("FAIL rst_req_ready: got %b, required 1", bus.req_ready); end
        n_vec++;
        if (bus.resp_valid !== 1'b0 || bus.resp_rdata !== 8'h00 || bus.flush_done !== 1'b0) begin
            n_err++; $display("FAIL rst_resp: got valid=%b rdata=%h done=%b, required 0 00 0", bus.resp_valid, bus.resp_rdata, bus.flush_done);
        end
        n_vec++;
        if (bus.mem_req !== 1'b0 || bus.mem_we !== 1'b0 || bus.mem_addr !== 8'h00 || bus.mem_wdata !== 8'h00) begin
            n_err++; $display("FAIL rst_mem: got req=%b we=%b addr=%h wdata=%h, required 0 0 00 00", bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata);
        end
        rst = 1'b1;
        @(negedge clk);
        n_vec++;
        if (bus.hit_cnt !== 0 || bus.miss_cnt !== 0 || bus.req_ready !== 1'b1) begin
            n_err++; $display("FAIL rst_counters: got hit=%0d miss=%0d ready=%b, required 0 0 1", bus.hit_cnt, bus.miss_cnt, bus.req_ready);
        end
    endtask

    task automatic test_read_miss_hit();
        int lat;
        issue(0, 8'h05, 8'h00); wait_resp(lat);
        n_vec++;
        if (bus.resp_rdata !== 8'hA5 || bus.miss_cnt !== 1) begin
            n_err++; $display("FAIL read_miss: got rdata=%h miss=%0d, required A5 1", bus.resp_rdata, bus.miss_cnt);
        end
        issue(0, 8'h05, 8'h00); wait_resp(lat);
        n_vec++;
        if (lat !== 3) begin n_err++; $display("FAIL hit_latency: got %0d, required 3", lat); end
        n_vec++;
        if (bus.hit_cnt !== 1) begin n_err++; $display("FAIL hit_count: got %0d, required 1", bus.hit_cnt); end
    endtask

    task automatic test_write_dirty_victim();
        int lat;
        issue(1, 8'h02, 8'h11); wait_resp(lat);
        issue(0, 8'h02, 8'h00); wait_resp(lat);
        n_vec++;
        if (bus.resp_rdata !== 8'h11) begin n_err++; $display("FAIL write_readback: got %h, required 11", bus.resp_rdata); end
        issue(0, 8'h06, 8'h00); wait_resp(lat);
        n_vec++;
        if (mem[8'h02] !== 8'h11 || exp_mem.size() != 0) begin
            n_err++; $display("FAIL victim_wb: got mem[02]=%h pending=%0d, required 11 0", mem[8'h02], exp_mem.size());
        end
    endtask

    task automatic test_flush();
        int lat;
        issue(1, 8'h00, 8'h33); wait_resp(lat);
        issue(1, 8'h03, 8'h44); wait_resp(lat);
        model_flush();
        pulse_flush(); wait_flush();
        n_vec++;
        if (mem[8'h00] !== 8'h33 || mem[8'h03] !== 8'h44) begin
            n_err++; $display("FAIL flush_data: got mem[00]=%h mem[03]=%h, required 33 44", mem[8'h00], mem[8'h03]);
        end
        model_flush();
        pulse_flush(); wait_flush();
        n_vec++;
        if (bus.hit_cnt !== CNT_W'(m_hit) || bus.miss_cnt !== CNT_W'(m_miss)) begin
            n_err++; $display("FAIL flush_counters: got hit=%0d miss=%0d, required %0d %0d", bus.hit_cnt, bus.miss_cnt, m_hit, m_miss);
        end
    endtask

    task automatic test_flush_priority();
        int lat, b, bad;
        issue(1, 8'h01, 8'h5C); wait_resp(lat);
        model_flush();
        model_access(0, 8'h09, 8'h00);
        bus.flush_req = 1'b1; bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_addr = 8'h09; bus.req_wdata = 8'h00;
        @(posedge clk); #1;
        bus.flush_req = 1'b0;
        b = 0; bad = 0;
        do begin
            @(negedge clk); b++;
            if (bus.flush_done !== 1'b1 && bus.req_ready !== 1'b0) bad++;
        end while (bus.flush_done !== 1'b1 && b < 300);
        n_vec++;
        if (b >= 300 || bad != 0) begin
            n_err++; $display("FAIL flush_priority: got %0d ready cycles, timeout=%0b, required 0 0", bad, b >= 300);
        end
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        wait_resp(lat);
        n_vec++;
        if (mem[8'h01] !== 8'h5C || exp_mem.size() != 0) begin
            n_err++; $display("FAIL flush_then_req: got mem[01]=%h pending=%0d, required 5C 0", mem[8'h01], exp_mem.size());
        end
    endtask

    task automatic test_mem_stall();
        int lat, b, hi, bad_stable, bad_ready, bad_drop;
        bit prev_req, prev_ack, got;
        logic [7:0] a0, d0;
        logic we0;
        issue(1, 8'h0E, 8'h77); wait_resp(lat);
        mem_delay = 10;
        issue(0, 8'h12, 8'h00);
        b = 0; hi = 0; bad_stable = 0; bad_ready = 0; bad_drop = 0;
        prev_req = 0; prev_ack = 0; got = 0; a0 = 0; d0 = 0; we0 = 0;
        while (!got && b < 300) begin
            @(negedge clk); #1; b++;
            if (prev_ack && bus.mem_req === 1'b1) bad_drop++;
            if (bus.mem_req === 1'b1) begin
                hi++;
                if (!prev_req) begin a0 = bus.mem_addr; d0 = bus.mem_wdata; we0 = bus.mem_we; end
                else if (bus.mem_addr !== a0 || bus.mem_wdata !== d0 || bus.mem_we !== we0) bad_stable++;
                if (bus.req_ready !== 1'b0) bad_ready++;
            end
            if (bus.resp_valid === 1'b1) got = 1;
            prev_req = (bus.mem_req === 1'b1);
            prev_ack = (bus.mem_ack === 1'b1);
        end
        mem_delay = 1;
        n_vec++;
        if (!got) begin n_err++; $display("FAIL stall_resp: got no response, required one"); end
        n_vec++;
        if (hi != 20) begin n_err++; $display("FAIL stall_req_cycles: got %0d, required 20", hi); end
        n_vec++;
        if (bad_stable != 0 || bad_ready != 0 || bad_drop != 0) begin
            n_err++; $display("FAIL stall_stable: got unstable=%0d ready=%0d no_drop=%0d, required 0 0 0", bad_stable, bad_ready, bad_drop);
        end
    endtask

    task automatic test_reset_mid_refill();
        int lat, b;
        mem_delay = 50;
        issue(0, 8'h16, 8'h00);
        b = 0;
        while (!(bus.mem_req === 1'b1 && bus.mem_we === 1'b0) && b < 100) begin @(negedge clk); b++; end
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        n_vec++;
        if (b >= 100 || bus.mem_req !== 1'b0 || bus.req_ready !== 1'b1) begin
            n_err++; $display("FAIL rst_mid: got mem_req=%b ready=%b timeout=%0b, required 0 1 0", bus.mem_req, bus.req_ready, b >= 100);
        end
        exp_resp.delete(); exp_mem.delete();
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        mem_delay = 1;
        n_vec++;
        if (bus.hit_cnt !== 0 || bus.miss_cnt !== 0) begin
            n_err++; $display("FAIL rst_mid_counters: got hit=%0d miss=%0d, required 0 0", bus.hit_cnt, bus.miss_cnt);
        end
        issue(0, 8'h05, 8'h00); wait_resp(lat);
        issue(0, 8'h09, 8'h00); wait_resp(lat);
        issue(0, 8'h12, 8'h00); wait_resp(lat);
        n_vec++;
        if (bus.miss_cnt !== 3 || bus.hit_cnt !== 0) begin
            n_err++; $display("FAIL rst_lines_lost: got hit=%0d miss=%0d, required 0 3", bus.hit_cnt, bus.miss_cnt);
        end
    endtask

    task automatic test_spurious_ack();
        int lat, bad;
        bad = 0;
        spurious = 1;
        repeat (4) begin
            @(negedge clk); #1;
            if (bus.req_ready !== 1'b1 || bus.mem_req !== 1'b0) bad++;
        end
        spurious = 0;
        n_vec++;
        if (bad != 0) begin n_err++; $display("FAIL spurious_ack: got %0d disturbed cycles, required 0", bad); end
        issue(0, 8'h05, 8'h00); wait_resp(lat);
    endtask

    task automatic test_back_to_back();
        int lat;
        for (int k = 0; k < 40; k++) begin
            mem_delay = $urandom_range(1, 3);
            issue(1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
            wait_resp(lat);
        end
        mem_delay = 1;
        model_flush();
        pulse_flush(); wait_flush();
        for (int a = 0; a < 16; a++) begin
            n_vec++;
            if (mem[a] !== m_mem[a]) begin
                n_err++; $display("FAIL b2b_mem[%0d]: got %h, required %h", a, mem[a], m_mem[a]);
            end
        end
        n_vec++;
        if (bus.hit_cnt !== CNT_W'(m_hit) || bus.miss_cnt !== CNT_W'(m_miss)) begin
            n_err++; $display("FAIL b2b_saturation: got hit=%0d miss=%0d, required %0d %0d", bus.hit_cnt, bus.miss_cnt, m_hit, m_miss);
        end
    endtask

    initial begin
        for (int a = 0; a < 256; a++) mem[a] = 8'(a) ^ 8'h5A;
        mem[8'h05] = 8'hA5;
        for (int a = 0; a < 256; a++) m_mem[a] = mem[a];
        test_reset();
        test_read_miss_hit();
        test_write_dirty_victim();
        test_flush();
        test_flush_priority();
        test_mem_stall();
        test_reset_mid_refill();
        test_spurious_ack();
        test_back_to_back();
        repeat (3) @(negedge clk);
        n_vec++;
        if (exp_resp.size() != 0 || exp_mem.size() != 0) begin
            n_err++; $display("FAIL end_pending: got resp=%0d mem=%0d outstanding, required 0 0", exp_resp.size(), exp_mem.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
